switch_axil_slave: RTL and testbench

- AXI4-Lite slave register block for the switch peripheral; the DUT that the master-VIP bench drives through the BD wrapper.
- Provides four RW registers at 0x0–0xC, which the bench writes 1..4 and reads back.
- Adds a debounced switch status register and LED output drive.
- Sits between the AXI interconnect/VIP master and the board switch/LED pins.

---
 rtl/switch_axil_pkg.sv | 25 ++
 rtl/switch_debounce.sv | 62 ++++++
 rtl/switch_axil_slave.sv | 155 +++++++++++++++
 tb/tb_switch_axil_slave.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_axil_pkg.sv
// Shared constants and helpers for the switch AXI4-Lite register block.
// Optional edge/interrupt logic is enabled with SWITCH_EDGE_IRQ_EN.
package switch_axil_pkg;

    localparam logic [2:0] REG0_IDX      = 3'd0;
    localparam logic [2:0] REG1_IDX      = 3'd1;
    localparam logic [2:0] REG2_IDX      = 3'd2;
    localparam logic [2:0] REG3_IDX      = 3'd3;
    localparam logic [2:0] SW_STATUS_IDX = 3'd4;
    localparam logic [2:0] EDGE_IDX      = 3'd5;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] r;
        r = old_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus per-bit stability counter for the switch pins.
// With SWITCH_EDGE_IRQ_EN an edge_pulse vector marks each debounced transition.
module switch_debounce #(
    parameter int unsigned NUM_SW          = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw_in,
`ifdef SWITCH_EDGE_IRQ_EN
    output logic [NUM_SW-1:0] edge_pulse,
`endif
    output logic [NUM_SW-1:0] sw_db
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_SW-1:0] sync1_q, sync1_d;
    logic [NUM_SW-1:0] sync2_q, sync2_d;
    logic [NUM_SW-1:0] db_q, db_d;
    logic [CW-1:0]     cnt_q [NUM_SW];
    logic [CW-1:0]     cnt_d [NUM_SW];

    always_comb begin
        sync1_d = sw_in;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        for (int unsigned i = 0; i < NUM_SW; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= CNT_MAX) begin
                // Take the new value at the terminal count; never wrap past it.
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int unsigned i = 0; i < NUM_SW; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sw_db = db_q;
`ifdef SWITCH_EDGE_IRQ_EN
    assign edge_pulse = db_d ^ db_q;
`endif

endmodule

// File: rtl/switch_axil_slave.sv
// AXI4-Lite slave: four RW registers, debounced switch status, LED drive.
// SWITCH_EDGE_IRQ_EN adds the W1C EDGE register and the irq output.
module switch_axil_slave
    import switch_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned NUM_SW             = 8,
    parameter int unsigned DEBOUNCE_CYCLES    = 100000
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [NUM_SW-1:0]               sw_in,
`ifdef SWITCH_EDGE_IRQ_EN
    output logic                            irq,
`endif
    output logic [NUM_SW-1:0]               led_out
);

    logic        awready_q, awready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];
    logic        wr_en, rd_en;
    logic [2:0]  widx, ridx;
    logic [31:0] rd_word;
    logic [NUM_SW-1:0] sw_db;
    logic        unused_ok;

`ifdef SWITCH_EDGE_IRQ_EN
    logic [NUM_SW-1:0] edge_pulse, edge_clr;
    logic [NUM_SW-1:0] edge_q, edge_d;
    logic              irq_q, irq_d;
`endif

    switch_debounce #(
        .NUM_SW          (NUM_SW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (S_AXI_ACLK),
        .rst_n      (S_AXI_ARESETN),
        .sw_in      (sw_in),
`ifdef SWITCH_EDGE_IRQ_EN
        .edge_pulse (edge_pulse),
`endif
        .sw_db      (sw_db)
    );

    assign widx = S_AXI_AWADDR[4:2];
    assign ridx = S_AXI_ARADDR[4:2];
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Acceptance and response share one edge so writes complete every 2 cycles.
    always_comb begin
        wr_en     = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
        rd_en     = S_AXI_ARVALID && !rvalid_q && !arready_q;
        awready_d = wr_en;
        arready_d = rd_en;
        bvalid_d  = wr_en || (bvalid_q && !S_AXI_BREADY);
        rvalid_d  = rd_en || (rvalid_q && !S_AXI_RREADY);

        regs_d = regs_q;
        if (wr_en && (widx <= REG3_IDX)) begin
            regs_d[widx[1:0]] = apply_wstrb(regs_q[widx[1:0]], S_AXI_WDATA, S_AXI_WSTRB);
        end

        rd_word = '0;
        case (ridx)
            REG0_IDX, REG1_IDX, REG2_IDX, REG3_IDX: rd_word = regs_q[ridx[1:0]];
            SW_STATUS_IDX:                          rd_word[NUM_SW-1:0] = sw_db;
`ifdef SWITCH_EDGE_IRQ_EN
            EDGE_IDX:                               rd_word[NUM_SW-1:0] = edge_q;
`endif
            default:                                rd_word = '0;
        endcase
        rdata_d = rd_en ? rd_word : rdata_q;
    end

`ifdef SWITCH_EDGE_IRQ_EN
    // A new edge in the same cycle as its W1C clear stays set.
    always_comb begin
        edge_clr = '0;
        if (wr_en && (widx == EDGE_IDX)) begin
            for (int unsigned i = 0; i < NUM_SW; i++) begin
                edge_clr[i] = S_AXI_WDATA[i] & S_AXI_WSTRB[i/8];
            end
        end
        edge_d = (edge_q & ~edge_clr) | edge_pulse;
        irq_d  = regs_q[3][0] && (|edge_q);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            edge_q <= edge_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign led_out       = regs_q[2][NUM_SW-1:0];

endmodule

// File: tb/tb_switch_axil_slave.sv
// Directed bench for switch_axil_slave; edge/irq steps only with SWITCH_EDGE_IRQ_EN.
module tb_switch_axil_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [7:0]  sw_in, led_out;
`ifdef SWITCH_EDGE_IRQ_EN
    logic        irq;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] rd_d;
    logic [1:0]  rd_r;
    logic        saw, held;

    always #5 clk = ~clk;

    switch_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .NUM_SW             (8),
        .DEBOUNCE_CYCLES    (16)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (3'b000),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (3'b000),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .sw_in         (sw_in),
`ifdef SWITCH_EDGE_IRQ_EN
        .irq           (irq),
`endif
        .led_out       (led_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int unsigned n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!awready && n < 20);
        chk("wr_accept", {31'd0, awready & wready}, 32'd1);
        chk("bresp", {30'd0, bresp}, 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int unsigned n;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!arready && n < 20);
        chk("rd_accept", {31'd0, arready & rvalid}, 32'd1);
        data = rdata; resp = rresp;
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; arvalid = 1'b0; rready = 1'b1;
        sw_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {28'd0, awready, wready, arready, 1'b0}, 32'd0);
        chk("rst_valid", {30'd0, bvalid, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_led", {24'd0, led_out}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Scratch/LED/control registers
        axi_write(5'h00, 32'h1, 4'hF);
        axi_write(5'h04, 32'h2, 4'hF);
        axi_write(5'h08, 32'h3, 4'hF);
        axi_write(5'h0C, 32'h4, 4'hF);
        axi_read(5'h00, rd_d, rd_r); chk("reg0", rd_d, 32'h1); chk("reg0_resp", {30'd0, rd_r}, 32'd0);
        axi_read(5'h04, rd_d, rd_r); chk("reg1", rd_d, 32'h2);
        axi_read(5'h08, rd_d, rd_r); chk("reg2", rd_d, 32'h3);
        axi_read(5'h0C, rd_d, rd_r); chk("reg3", rd_d, 32'h4);
        chk("led", {24'd0, led_out}, 32'h03);

        // Byte strobes
        axi_write(5'h00, 32'hFFFF_FFFF, 4'hF);
        axi_write(5'h00, 32'h0000_00AB, 4'b0001);
        axi_read(5'h00, rd_d, rd_r); chk("wstrb", rd_d, 32'hFFFF_FFAB);

        // Debounce: short glitch ignored
        sw_in[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1; sw_in[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        axi_read(5'h10, rd_d, rd_r); chk("glitch", rd_d, 32'h0);

        // Debounce: steady level taken after 2 sync + 16 stable cycles
        sw_in[0] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        axi_read(5'h10, rd_d, rd_r); chk("db_early", rd_d, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        axi_read(5'h10, rd_d, rd_r); chk("db_taken", rd_d, 32'h1);
        repeat (20) @(posedge clk);
        #1;
        axi_read(5'h10, rd_d, rd_r); chk("db_hold", rd_d, 32'h1);

`ifdef SWITCH_EDGE_IRQ_EN
        axi_write(5'h14, 32'hFF, 4'hF);
        axi_write(5'h0C, 32'h1, 4'hF);
        axi_read(5'h14, rd_d, rd_r); chk("edge_cleared", rd_d, 32'h0);
        sw_in[2] = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        axi_read(5'h14, rd_d, rd_r); chk("edge_set", rd_d, 32'h4);
        chk("irq_set", {31'd0, irq}, 32'd1);
        axi_write(5'h14, 32'h4, 4'hF);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        axi_read(5'h14, rd_d, rd_r); chk("edge_w1c", rd_d, 32'h0);
        // Falling edge of bit2 lands on the accept edge of the clear
        sw_in[2] = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        axi_write(5'h14, 32'h4, 4'hF);
        axi_read(5'h14, rd_d, rd_r); chk("edge_set_wins", rd_d, 32'h4);
        axi_write(5'h0C, 32'h4, 4'hF);
`else
        axi_read(5'h14, rd_d, rd_r); chk("edge_absent", rd_d, 32'h0);
`endif

        // AW ahead of W, then BREADY held low
        awaddr = 5'h04; wdata = 32'h11; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            @(posedge clk); #1; saw |= awready;
        end
        chk("aw_only_stall", {31'd0, saw}, 32'd0);
        wvalid = 1'b1;
        for (int i = 0; i < 10 && !awready; i++) begin
            @(posedge clk); #1;
        end
        chk("aw_w_accept", {31'd0, awready}, 32'd1);
        @(posedge clk); #1;
        awaddr = 5'h00; wdata = 32'h55;
        saw = 1'b0; held = 1'b1;
        repeat (10) begin
            @(posedge clk); #1; saw |= awready; held &= bvalid;
        end
        chk("bvalid_held", {31'd0, held}, 32'd1);
        chk("no_accept_bvalid", {31'd0, saw}, 32'd0);
        bready = 1'b1;
        for (int i = 0; i < 10 && !awready; i++) begin
            @(posedge clk); #1;
        end
        chk("second_accept", {31'd0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        axi_read(5'h04, rd_d, rd_r); chk("stall_wr1", rd_d, 32'h11);
        axi_read(5'h00, rd_d, rd_r); chk("stall_wr2", rd_d, 32'h55);

        // Reset during an outstanding write response
        awaddr = 5'h08; wdata = 32'hA5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        for (int i = 0; i < 10 && !awready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_pending", {31'd0, bvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_led_mid", {24'd0, led_out}, 32'd0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_bvalid", {31'd0, bvalid}, 32'd0);
        axi_read(5'h00, rd_d, rd_r); chk("post_rst_reg0", rd_d, 32'h0);
        axi_read(5'h08, rd_d, rd_r); chk("post_rst_reg2", rd_d, 32'h0);
        axi_write(5'h18, 32'hDEAD_BEEF, 4'hF);
        axi_read(5'h18, rd_d, rd_r); chk("unmapped", rd_d, 32'h0);
        chk("unmapped_resp", {30'd0, rd_r}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
